// File: rtl/abft_checksum_checker.sv
// abft_checksum_checker: ABFT residual checker placed after the four-lane dot-product stage.
// Lane d carries the checksum row. The block computes |ae+be+ce-de|, compares it with a
// programmable tolerance, and reports the fault through a valid/ready handshake.
// Optional statistics (chk_count, stats_clear) are built when ABFT_CHK_STATS_EN is defined.
module abft_checksum_checker #(
   parameter int unsigned zBits   = 28,
   parameter int unsigned rBits   = 30,
   parameter int unsigned cntBits = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [zBits-1:0]   ae_dot,
   input  logic [zBits-1:0]   be_dot,
   input  logic [zBits-1:0]   ce_dot,
   input  logic [zBits-1:0]   de_dot,
   input  logic [rBits-1:0]   threshold,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               fault,
   output logic [rBits-1:0]   residual,
`ifdef ABFT_CHK_STATS_EN
   output logic [cntBits-1:0] chk_count,
   input  logic               stats_clear,
`endif
   output logic [cntBits-1:0] err_count
);

   localparam int unsigned ExtBits = rBits - zBits;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SUM    = 2'd1,
      DIFF   = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [zBits-1:0]   ae_q, ae_d;
   logic [zBits-1:0]   be_q, be_d;
   logic [zBits-1:0]   ce_q, ce_d;
   logic [zBits-1:0]   dcap_q, dcap_d;
   logic [rBits-1:0]   thr_q, thr_d;
   logic [rBits-1:0]   sum_q, sum_d;
   logic [rBits-1:0]   de_q, de_d;
   logic [rBits-1:0]   residual_q, residual_d;
   logic               fault_q, fault_d;
   logic [cntBits-1:0] err_q, err_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [rBits-1:0]   diff_c;
   logic [rBits-1:0]   mag_c;
`ifdef ABFT_CHK_STATS_EN
   logic [cntBits-1:0] chk_q, chk_d;
`endif

   // Sign-extend a lane result to the residual width
   function automatic logic [rBits-1:0] sext(input logic [zBits-1:0] v);
      return {{ExtBits{v[zBits-1]}}, v};
   endfunction

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ae_q        <= '0;
         be_q        <= '0;
         ce_q        <= '0;
         dcap_q      <= '0;
         thr_q       <= '0;
         sum_q       <= '0;
         de_q        <= '0;
         residual_q  <= '0;
         fault_q     <= 1'b0;
         err_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef ABFT_CHK_STATS_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ae_q        <= ae_d;
         be_q        <= be_d;
         ce_q        <= ce_d;
         dcap_q      <= dcap_d;
         thr_q       <= thr_d;
         sum_q       <= sum_d;
         de_q        <= de_d;
         residual_q  <= residual_d;
         fault_q     <= fault_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef ABFT_CHK_STATS_EN
         chk_q       <= chk_d;
`endif
      end
   end

   // Next-state, datapath and statistics update
   always_comb begin
      state_d    = state_q;
      ae_d       = ae_q;
      be_d       = be_q;
      ce_d       = ce_q;
      dcap_d     = dcap_q;
      thr_d      = thr_q;
      sum_d      = sum_q;
      de_d       = de_q;
      residual_d = residual_q;
      fault_d    = fault_q;
      err_d      = err_q;
`ifdef ABFT_CHK_STATS_EN
      chk_d      = chk_q;
`endif
      // rBits = zBits+2, so neither the difference nor its magnitude can wrap
      diff_c     = sum_q - de_q;
      mag_c      = diff_c[rBits-1] ? (rBits'(0) - diff_c) : diff_c;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               ae_d    = ae_dot;
               be_d    = be_dot;
               ce_d    = ce_dot;
               dcap_d  = de_dot;
               thr_d   = threshold;
               state_d = SUM;
            end
         end
         SUM: begin
            sum_d   = sext(ae_q) + sext(be_q) + sext(ce_q);
            de_d    = sext(dcap_q);
            state_d = DIFF;
         end
         DIFF: begin
            residual_d = mag_c;
            fault_d    = (mag_c > thr_q);
            state_d    = RESULT;
         end
         RESULT: begin
            if (out_ready) begin
               state_d = IDLE;
               if (fault_q && (err_q != {cntBits{1'b1}})) begin
                  err_d = err_q + cntBits'(1);
               end
`ifdef ABFT_CHK_STATS_EN
               if (chk_q != {cntBits{1'b1}}) begin
                  chk_d = chk_q + cntBits'(1);
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef ABFT_CHK_STATS_EN
      if (stats_clear) begin
         err_d = '0;
         chk_d = '0;
      end
`endif

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == RESULT);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign fault     = fault_q;
   assign residual  = residual_q;
   assign err_count = err_q;
`ifdef ABFT_CHK_STATS_EN
   assign chk_count = chk_q;
`endif

endmodule
